// File: rtl/out_uart_tx.sv
// rtl/out_uart_tx.sv - FIFO-buffered UART transmitter for 16-bit core output words, high byte first
// Optional even parity bit after data bit 7: define OUT_UART_TX_PARITY_EN.
module out_uart_tx #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_en,
    input  logic [15:0] out_dat,
    input  logic        is_halt,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        overflow,
    output logic        drained
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef OUT_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic          push, pop;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic          sel_hi, sel_hi_next;
    logic [15:0]   word, word_next;
    logic [7:0]    cur_byte;
    logic          bit_end, tx_next, halt_seen, halt_next;

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        sel_hi_next  = sel_hi;
        word_next    = word;
        pop          = 1'b0;
        bit_end      = (timer == TIMER_LAST);
        timer_next   = bit_end ? '0 : timer + TW'(1);
        case (state)
            IDLE: begin
                timer_next = '0;
                if (count != '0) begin
                    pop         = 1'b1;
                    word_next   = mem[rd_ptr];
                    sel_hi_next = 1'b1;
                    state_next  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef OUT_UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef OUT_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (sel_hi) begin
                        sel_hi_next = 1'b0;
                        state_next  = START;
                    end else if (count != '0) begin
                        // Chain straight into the next word so back-to-back words have no idle gap
                        pop         = 1'b1;
                        word_next   = mem[rd_ptr];
                        sel_hi_next = 1'b1;
                        state_next  = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        push = out_en && ((count != DEPTH_C) || pop);
        case ({push, pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase

        // tx is driven from the post-edge state so the line is a plain register
        cur_byte = sel_hi_next ? word_next[15:8] : word_next[7:0];
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = cur_byte[bit_idx_next];
`ifdef OUT_UART_TX_PARITY_EN
            PARITY:  tx_next = ^cur_byte;
`endif
            default: tx_next = 1'b1;
        endcase
        halt_next = halt_seen | is_halt;
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= out_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            sel_hi    <= 1'b0;
            word      <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            drained   <= 1'b0;
            halt_seen <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            state     <= state_next;
            timer     <= timer_next;
            bit_idx   <= bit_idx_next;
            sel_hi    <= sel_hi_next;
            word      <= word_next;
            tx        <= tx_next;
            busy      <= (state_next != IDLE) || (count_next != '0);
            full      <= (count_next == DEPTH_C);
            overflow  <= overflow | (out_en & ~push);
            drained   <= halt_next && (count_next == '0) && (state_next == IDLE);
            halt_seen <= halt_next;
        end
    end
endmodule

// File: tb/tb_out_uart_tx.sv
// tb/tb_out_uart_tx.sv - randomized/directed bench for out_uart_tx against a bit-timeline UART model
module tb_out_uart_tx;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef OUT_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int WB = 2 * FB;

    logic        clk = 1'b0;
    logic        reset, out_en, is_halt;
    logic [15:0] out_dat;
    logic        tx, busy, full, overflow, drained;

    out_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .out_en(out_en), .out_dat(out_dat), .is_halt(is_halt),
        .tx(tx), .busy(busy), .full(full), .overflow(overflow), .drained(drained)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int fe = 0;
    int c0;
    logic [15:0] sw [0:7];
    logic        wave [0:511];
    logic        bsy  [0:511];
    logic        drn  [0:511];
    logic        ful  [0:511];
    logic        ovf  [0:511];
    logic [7:0]  rxq [$];
    int          rxt [$];
    logic [7:0]  expq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver: finds start edges, samples each bit mid-way, checks start/parity/stop.
    initial begin
        int  m_cnt, k, m_start;
        bit  m_act;
        logic [7:0] m_byte;
        m_act = 0; m_cnt = 0; m_start = 0; m_byte = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                m_act = 0;
            end else begin
                if (!m_act && tx === 1'b0) begin
                    m_act = 1; m_cnt = 0; m_start = cyc;
                end
                if (m_act) begin
                    if (m_cnt % CPB == CPB / 2) begin
                        k = m_cnt / CPB;
                        if (k == 0) begin
                            if (tx !== 1'b0) fe++;
                        end else if (k <= 8) begin
                            m_byte[k-1] = tx;
                        end else if (k == FB - 1) begin
                            if (tx !== 1'b1) fe++;
                            rxq.push_back(m_byte);
                            rxt.push_back(m_start);
                            m_act = 0;
                        end else if (tx !== ^m_byte) begin
                            fe++;
                        end
                    end
                    m_cnt++;
                end
            end
        end
    end

    function automatic logic frame_bit(input logic [15:0] w, input int k);
        logic [7:0] b;
        int j;
        b = (k < FB) ? w[15:8] : w[7:0];
        j = k % FB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (j == FB - 1) return 1'b1;
        return ^b;
    endfunction

    // Expected line level i cycles after the first strobe, for nacc gapless words.
    function automatic logic exp_tx(input int i, input int nacc);
        int t;
        if (i < 2) return 1'b1;
        t = (i - 2) / CPB;
        if (t / WB >= nacc) return 1'b1;
        return frame_bit(sw[t / WB], t % WB);
    endfunction

    task automatic send_capture(input int nw, input int n, input int halt_at);
        c0 = cyc;
        rxq.delete(); rxt.delete();
        for (int i = 0; i < n; i++) begin
            out_en  = (i < nw);
            out_dat = (i < nw) ? sw[i] : 16'h0;
            is_halt = (i == halt_at);
            wave[i] = tx; bsy[i] = busy; drn[i] = drained; ful[i] = full; ovf[i] = overflow;
            @(negedge clk);
        end
        out_en = 0; is_halt = 0;
    endtask

    task automatic check_wave(input string tag, input int nacc, input int n);
        int mism = 0;
        for (int i = 0; i < n; i++)
            if (wave[i] !== exp_tx(i, nacc)) mism++;
        check(tag, mism, 0);
    endtask

    task automatic check_rx(input string tag, input int nacc);
        check({tag, "_count"}, rxq.size(), 2 * nacc);
        for (int i = 0; i < nacc && 2 * i + 1 < rxq.size(); i++) begin
            check($sformatf("%s_hi%0d", tag, i), rxq[2*i],   sw[i][15:8]);
            check($sformatf("%s_lo%0d", tag, i), rxq[2*i+1], sw[i][7:0]);
        end
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (busy !== 1'b0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < lim), 1);
    endtask

    initial begin
        int n, nw, gap, k, bad;
        reset = 1; out_en = 0; out_dat = '0; is_halt = 0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drained", drained, 0);
        reset = 0;
        repeat (2) @(negedge clk);

        // single word 0xA55A
        sw[0] = 16'hA55A;
        n = 2 + WB * CPB + 6;
        send_capture(1, n, -1);
        check("t1_pre_start", wave[1], 1);
        check("t1_start", wave[2], 0);
        for (int b = 0; b < WB; b++)
            check($sformatf("t1_bit%0d", b), wave[2 + b*CPB + CPB/2], frame_bit(sw[0], b));
        check_wave("t1_wave", 1, n);
        check("t1_busy_last", bsy[1 + WB*CPB], 1);
        check("t1_idle_at", bsy[2 + WB*CPB], 0);
        check_rx("t1_rx", 1);
        check("t1_start_cycle", rxt.size() > 0 ? rxt[0] - c0 : -1, 2);

        // back-to-back words
        sw[0] = 16'h0001; sw[1] = 16'hFF00;
        n = 2 + 2 * WB * CPB + 6;
        send_capture(2, n, -1);
        check_wave("t2_wave", 2, n);
        check_rx("t2_rx", 2);
        check("t2_busy_end", bsy[1 + 2*WB*CPB], 1);
        check("t2_idle_end", bsy[2 + 2*WB*CPB], 0);
        check("t2_gapless", rxt.size() == 4 ? rxt[3] - rxt[0] : -1, 3 * FB * CPB);

        // random bursts with small gaps, never more than DEPTH+1 words outstanding
        for (int r = 0; r < 6; r++) begin
            rxq.delete(); rxt.delete();
            nw = $urandom_range(1, DEPTH + 1);
            for (int j = 0; j < nw; j++) begin
                sw[j] = 16'($urandom);
                out_en = 1; out_dat = sw[j];
                @(negedge clk);
                out_en = 0;
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
            end
            wait_idle($sformatf("r%0d_idle", r), (DEPTH + 2) * WB * CPB + 50);
            repeat (2) @(negedge clk);
            check_rx($sformatf("r%0d_rx", r), nw);
            check($sformatf("r%0d_ovf", r), overflow, 0);
        end

        // overflow: 6 consecutive words into DEPTH=4
        for (int j = 0; j < 6; j++) sw[j] = 16'($urandom);
        n = 2 + (DEPTH + 1) * WB * CPB + 10;
        send_capture(6, n, -1);
        check("t4_full_c4", ful[4], 0);
        check("t4_full_c5", ful[5], 1);
        check("t4_ovf_c5", ovf[5], 0);
        check("t4_ovf_c6", ovf[6], 1);
        check_wave("t4_wave", DEPTH + 1, n);
        check_rx("t4_rx", DEPTH + 1);
        check("t4_ovf_sticky", overflow, 1);
        check("t4_busy_end", busy, 0);

        // reset mid-frame with three words queued
        for (int j = 0; j < 3; j++) sw[j] = 16'($urandom);
        send_capture(3, 2 + CPB + 5, -1);
        reset = 1;
        @(negedge clk);
        check("t5_tx", tx, 1);
        check("t5_busy", busy, 0);
        check("t5_full", full, 0);
        check("t5_ovf", overflow, 0);
        @(negedge clk);
        reset = 0;
        bad = 0;
        for (int i = 0; i < 3 * WB * CPB; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("t5_quiet", bad, 0);
        check("t5_no_rx", rxq.size(), 0);
        sw[0] = 16'h1234;
        n = 2 + WB * CPB + 6;
        send_capture(1, n, -1);
        check_wave("t5_wave", 1, n);
        check_rx("t5_rx", 1);

`ifdef OUT_UART_TX_PARITY_EN
        sw[0] = 16'h0301;
        n = 2 + WB * CPB + 6;
        send_capture(1, n, -1);
        check("p_par_hi", wave[2 + 9*CPB + CPB/2], 0);
        check("p_par_lo", wave[2 + (FB+9)*CPB + CPB/2], 1);
        check("p_busy_last", bsy[1 + 22*CPB], 1);
        check("p_idle", bsy[2 + 22*CPB], 0);
        check_wave("p_wave", 1, n);
`endif

        // drain: halt pulsed mid-transmission of two words
        sw[0] = 16'($urandom); sw[1] = 16'($urandom);
        n = 2 + 2 * WB * CPB + 20;
        send_capture(2, n, 50);
        bad = 0;
        for (int i = 0; i < n; i++)
            if (drn[i] !== logic'(i >= 2 + 2 * WB * CPB)) bad++;
        check("t6_drained_timeline", bad, 0);
        check("t6_drained_now", drained, 1);
        check_rx("t6_rx", 2);
        // a write after halt is still accepted and sent
        sw[0] = 16'hBEEF;
        n = 2 + WB * CPB + 6;
        send_capture(1, n, -1);
        check("t6_post_d0", drn[0], 1);
        check("t6_post_d1", drn[1], 0);
        check("t6_post_dend", drn[2 + WB*CPB], 1);
        check_wave("t6_post_wave", 1, n);
        check_rx("t6_post_rx", 1);

        check("frame_errors", fe, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/out_uart_tx.md
# out_uart_tx

Output-port serializer sitting directly downstream of the core's `out_en`/`out_dat` port. It captures every 16-bit word the core writes, buffers it in a FIFO and transmits it on a single 8N1 UART line, high byte first. It also reports when the halted core's output has fully drained. The core never stalls on output; words arriving while the FIFO is full are dropped and flagged.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in 16-bit words; power of two, ≥ 2.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit; ≥ 2.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `out_en`  in  1  core output strobe; one word per high cycle.
- `out_dat`  in  16  core output word, valid when `out_en`=1.
- `is_halt`  in  1  core halted indication.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.
- `full`  out  1  FIFO count == `DEPTH`.
- `overflow`  out  1  sticky; a word was dropped.
- `drained`  out  1  halt seen, FIFO empty, FSM IDLE.

## Operation
- **FIFO**:
  - Circular buffer with read/write pointers of log2(`DEPTH`) bits and a count of log2(`DEPTH`)+1 bits.
  - Push when `out_en`=1 and (count < `DEPTH` or a pop occurs in the same cycle).
  - Push when full with no pop: word discarded, `overflow` set until reset.
  - Push and pop in the same cycle: count unchanged.
- **FSM states**: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - Registers: bit-timer 0..`CLKS_PER_BIT`-1, bit index 0..7, byte select (HI/LO), 16-bit word register.
- **IDLE**:
  - `tx`=1.
  - FIFO non-empty: pop into the word register, select HI, go to START.
- **START**: `tx`=0 for one bit time, then DATA.
- **DATA**:
  - `tx` = selected byte, LSB first.
  - Advance bit index each bit time.
  - After bit 7: PARITY if compiled in, else STOP.
- **STOP**: `tx`=1 for one bit time, then:
  - Byte was HI: select LO, go to START. No idle gap between the two bytes of a word.
  - Byte was LO and FIFO non-empty: pop the next word, select HI, go to START.
  - Otherwise: go to IDLE.
- **Halt**:
  - Sticky `halt_seen` is set when `is_halt`=1; cleared only by reset.
  - `drained` = `halt_seen` & FIFO empty & IDLE.
  - Writes arriving after halt are still accepted.
- **Reset**, at any point including mid-frame, takes effect on the next edge:
  - FIFO emptied, FSM to IDLE, timers cleared.
  - Outputs: `tx`=1, `busy`=0, `full`=0, `overflow`=0, `drained`=0.

## Timing
- `tx` is registered; no combinational path from inputs to `tx`.
- Latency: `out_en` high in cycle 0 with FSM idle → word in FIFO from cycle 1 → popped at end of cycle 1 → `tx`=0 from cycle 2.
- Each bit holds exactly `CLKS_PER_BIT` cycles.
- Frame lengths, without / with the macro:
  - Byte: 10 / 11 bits.
  - Word: 20 / 22 bits.
- Back-to-back words have no idle bit between them.
- `full`, `overflow`, `busy` and `drained` are registered and reflect state after the edge.
- Sustained input faster than one word per 20·`CLKS_PER_BIT` cycles overflows after about `DEPTH`+1 words.

## Configuration
- `OUT_UART_TX_PARITY_EN`:
  - Defined: an even-parity bit is inserted after data bit 7. Its value is the XOR of the 8 data bits, so the total count of ones including parity is even. It holds for one bit time.
  - Undefined: no PARITY state, frame is 8N1.

## Test plan
- **Single word**: `CLKS_PER_BIT`=4, push 0xA55A.
  - `tx` low from cycle 2.
  - Bits, sampled mid-bit: 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1.
  - Back to IDLE at cycle 82.
- **Back-to-back**: push 0x0001 and 0xFF00 in consecutive cycles.
  - 40 bit times with no idle gap, bytes 0x00,0x01,0xFF,0x00.
  - `busy` low afterwards.
- **Overflow**: `DEPTH`=4, push 6 words in cycles 0–5.
  - First 5 accepted, `full`=1 after cycle 4, 6th dropped, `overflow`=1.
  - Exactly 5 words transmitted; `overflow` stays 1.
- **Drain**: push 2 words, pulse `is_halt` mid-transmission.
  - `drained`=0 until the final stop bit ends, then 1 and stays 1.
- **Reset mid-frame**: assert `reset` during DATA of the first byte with 3 words queued.
  - Next cycle: `tx`=1, `busy`=0, `full`=0; no further bits sent.
  - A new push afterwards transmits normally.
- **Parity** (macro defined): push 0x0301.
  - Parity bits 0 for 0x03 and 1 for 0x01.
  - Word frame is 22 bit times.
